miter_lockstep_cmp: RTL and testbench

- Parametrised, clocked output-equivalence checker for the mutation flow.
- Compares NUM_CH reference channels against NUM_CH unit-under-test channels; each channel is CH_W bits wide.
- Reference stream passes through a REF_DELAY-stage alignment pipeline, so a UUT with fixed extra latency can be checked.
- Adds per-channel masking, post-reset warm-up suppression, a sticky fail flag, first-mismatch capture and a saturating mismatch counter.
- Sits beside two core instances and feeds formal asserts or a bench scoreboard.

---
 rtl/miter_lockstep_cmp.sv | 207 ++++++++++++++++++++
 tb/tb_miter_lockstep_cmp.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/miter_lockstep_cmp.sv
// ---------------------------------------------------------------------------
// miter_lockstep_cmp
// Clocked output-equivalence checker placed beside a reference core and a
// unit-under-test core. The reference stream is aligned by REF_DELAY register
// stages, then compared channel by channel against the UUT stream once the
// post-reset warm-up window has elapsed. Reports a one-cycle mismatch pulse
// with a per-channel vector, a sticky fail flag, the details of the first
// failing compare and a saturating count of failing compares.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   ref_valid_i     reference sample valid
//   ref_data_i      reference channels, channel k at [k*CH_W +: CH_W]
//   uut_valid_i     UUT sample valid
//   uut_data_i      UUT channels, same packing
//   ch_mask_i       1 = channel excluded from compare
//   clear_i         clears sticky, capture, counter and pulse outputs
//   mismatch_o      mismatch detected on the previous cycle
//   mismatch_vec_o  per-channel mismatch bits of that cycle
//   fail_o          sticky: any mismatch since reset or clear
//   first_ch_o      lowest mismatching channel of the first failure
//   first_cycle_o   cycle stamp of the first failure
//   first_ref_o     aligned reference value of first_ch_o at first failure
//   first_uut_o     UUT value of first_ch_o at first failure
//   mismatch_cnt_o  saturating count of failing compare cycles
//   warm_o          warm-up window has elapsed
// ---------------------------------------------------------------------------
module miter_lockstep_cmp #(
   parameter int NUM_CH    = 16,
   parameter int CH_W      = 32,
   parameter int REF_DELAY = 0,
   parameter int WARMUP    = 4,
   parameter int CNT_W     = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   ref_valid_i,
   input  logic [NUM_CH*CH_W-1:0] ref_data_i,
   input  logic                   uut_valid_i,
   input  logic [NUM_CH*CH_W-1:0] uut_data_i,
   input  logic [NUM_CH-1:0]      ch_mask_i,
   input  logic                   clear_i,
   output logic                   mismatch_o,
   output logic [NUM_CH-1:0]      mismatch_vec_o,
   output logic                   fail_o,
   output logic [5:0]             first_ch_o,
   output logic [31:0]            first_cycle_o,
   output logic [CH_W-1:0]        first_ref_o,
   output logic [CH_W-1:0]        first_uut_o,
   output logic [CNT_W-1:0]       mismatch_cnt_o,
   output logic                   warm_o
);

   localparam int         DW       = NUM_CH * CH_W;
   localparam logic [7:0] WARMUP_C = 8'(WARMUP);
   localparam logic [5:0] LAST_CH  = 6'(NUM_CH - 1);

   logic [DW-1:0]     ref_a_s;
   logic              ref_va_s;
   logic [NUM_CH-1:0] vec_s;
   logic              mis_s;
   logic [5:0]        idx_s;
   logic [CH_W-1:0]   sel_ref_s;
   logic [CH_W-1:0]   sel_uut_s;

   logic [7:0]        warm_cnt_r;
   logic              warm_r;
   logic [31:0]       cyc_r;
   logic              mismatch_r;
   logic [NUM_CH-1:0] vec_r;
   logic              fail_r;
   logic [5:0]        first_ch_r;
   logic [31:0]       first_cycle_r;
   logic [CH_W-1:0]   first_ref_r;
   logic [CH_W-1:0]   first_uut_r;
   logic [CNT_W-1:0]  cnt_r;

   generate
      if (REF_DELAY == 0) begin : g_no_delay
         assign ref_a_s  = ref_data_i;
         assign ref_va_s = ref_valid_i;
      end else begin : g_delay
         logic [DW-1:0]        dly_data_r [REF_DELAY];
         logic [REF_DELAY-1:0] dly_valid_r;

         // Alignment shift register: advances every cycle, flushed by reset.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int i = 0; i < REF_DELAY; i++) begin
                  dly_data_r[i]  <= '0;
                  dly_valid_r[i] <= 1'b0;
               end
            end else begin
               dly_data_r[0]  <= ref_data_i;
               dly_valid_r[0] <= ref_valid_i;
               for (int i = 1; i < REF_DELAY; i++) begin
                  dly_data_r[i]  <= dly_data_r[i-1];
                  dly_valid_r[i] <= dly_valid_r[i-1];
               end
            end
         end

         assign ref_a_s  = dly_data_r[REF_DELAY-1];
         assign ref_va_s = dly_valid_r[REF_DELAY-1];
      end
   endgenerate

   // Mismatch detection for the current cycle plus lowest-channel selection.
   always_comb begin
      vec_s     = '0;
      mis_s     = 1'b0;
      idx_s     = LAST_CH;
      sel_ref_s = ref_a_s[(NUM_CH-1)*CH_W +: CH_W];
      sel_uut_s = uut_data_i[(NUM_CH-1)*CH_W +: CH_W];
      if (warm_r && (ref_va_s != uut_valid_i)) begin
         // Valid skew fails every unmasked channel; data is ignored. With all
         // channels masked it still counts as a mismatch (on the last channel).
         vec_s = ~ch_mask_i;
         mis_s = 1'b1;
      end else if (warm_r && ref_va_s && uut_valid_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            vec_s[k] = !ch_mask_i[k] &&
                       (ref_a_s[k*CH_W +: CH_W] != uut_data_i[k*CH_W +: CH_W]);
         end
         mis_s = |vec_s;
      end else begin
         vec_s = '0;
         mis_s = 1'b0;
      end
      // Descending scan so the lowest set channel is the one that remains.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (vec_s[k]) begin
            idx_s     = 6'(k);
            sel_ref_s = ref_a_s[k*CH_W +: CH_W];
            sel_uut_s = uut_data_i[k*CH_W +: CH_W];
         end else begin
         end
      end
   end

   // Warm-up window and free-running saturating cycle stamp.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         warm_cnt_r <= 8'd0;
         warm_r     <= 1'b0;
         cyc_r      <= 32'd0;
      end else begin
         if (warm_cnt_r == WARMUP_C) begin
            warm_r <= 1'b1;
         end else begin
            warm_cnt_r <= warm_cnt_r + 8'd1;
         end
         if (cyc_r != 32'hFFFF_FFFF) begin
            cyc_r <= cyc_r + 32'd1;
         end else begin
            cyc_r <= cyc_r;
         end
      end
   end

   // Result pulse, sticky flag, first-failure capture and failure counter.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         mismatch_r    <= 1'b0;
         vec_r         <= '0;
         fail_r        <= 1'b0;
         first_ch_r    <= 6'd0;
         first_cycle_r <= 32'd0;
         first_ref_r   <= '0;
         first_uut_r   <= '0;
         cnt_r         <= '0;
      end else begin
         mismatch_r <= mis_s;
         vec_r      <= vec_s;
         if (mis_s) begin
            fail_r <= 1'b1;
            if (!fail_r) begin
               first_ch_r    <= idx_s;
               first_cycle_r <= cyc_r;
               first_ref_r   <= sel_ref_s;
               first_uut_r   <= sel_uut_s;
            end else begin
               first_ch_r <= first_ch_r;
            end
            if (cnt_r != {CNT_W{1'b1}}) begin
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_r <= cnt_r;
            end
         end else begin
            fail_r <= fail_r;
         end
      end
   end

   assign mismatch_o     = mismatch_r;
   assign mismatch_vec_o = vec_r;
   assign fail_o         = fail_r;
   assign first_ch_o     = first_ch_r;
   assign first_cycle_o  = first_cycle_r;
   assign first_ref_o    = first_ref_r;
   assign first_uut_o    = first_uut_r;
   assign mismatch_cnt_o = cnt_r;
   assign warm_o         = warm_r;

endmodule

// File: tb/tb_miter_lockstep_cmp.sv
// ---------------------------------------------------------------------------
// tb_miter_lockstep_cmp
// Randomized bench: a UUT stream is built from the reference history with
// occasional corruption, valid skew, masking, clears and resets. Expected
// outputs come from a model that indexes the reference history by cycle
// number since the last reset.
// ---------------------------------------------------------------------------
module tb_miter_lockstep_cmp;

   localparam int NCH  = 4;
   localparam int CW   = 8;
   localparam int D    = 2;
   localparam int W    = 3;
   localparam int CNTW = 3;
   localparam int CMAX = (1 << CNTW) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              ref_valid;
   logic [NCH*CW-1:0] ref_data;
   logic              uut_valid;
   logic [NCH*CW-1:0] uut_data;
   logic [NCH-1:0]    ch_mask;
   logic              clear;
   logic              mismatch;
   logic [NCH-1:0]    mismatch_vec;
   logic              fail;
   logic [5:0]        first_ch;
   logic [31:0]       first_cycle;
   logic [CW-1:0]     first_ref;
   logic [CW-1:0]     first_uut;
   logic [CNTW-1:0]   mismatch_cnt;
   logic              warm;

   miter_lockstep_cmp #(
      .NUM_CH(NCH), .CH_W(CW), .REF_DELAY(D), .WARMUP(W), .CNT_W(CNTW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .ref_valid_i(ref_valid), .ref_data_i(ref_data),
      .uut_valid_i(uut_valid), .uut_data_i(uut_data),
      .ch_mask_i(ch_mask), .clear_i(clear),
      .mismatch_o(mismatch), .mismatch_vec_o(mismatch_vec), .fail_o(fail),
      .first_ch_o(first_ch), .first_cycle_o(first_cycle),
      .first_ref_o(first_ref), .first_uut_o(first_uut),
      .mismatch_cnt_o(mismatch_cnt), .warm_o(warm)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state
   logic [NCH*CW-1:0] hist_d [4096];
   logic              hist_v [4096];
   int                n = 0;
   logic              e_mis = 1'b0;
   logic [NCH-1:0]    e_vec = '0;
   logic              e_fail = 1'b0;
   int                e_ch = 0;
   int                e_cyc = 0;
   int                e_ref = 0;
   int                e_uut = 0;
   int                e_cnt = 0;
   logic              e_warm = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic int chan(input logic [NCH*CW-1:0] v, input int k);
      return int'((v >> (CW * k)) & 32'hFF);
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic step_model();
      logic [NCH*CW-1:0] ra;
      logic              rva;
      logic              wm;
      logic              m;
      logic [NCH-1:0]    v;
      int                lo;
      if (rst) begin
         n = 0; e_mis = 1'b0; e_vec = '0; e_fail = 1'b0; e_ch = 0; e_cyc = 0;
         e_ref = 0; e_uut = 0; e_cnt = 0; e_warm = 1'b0;
         return;
      end
      hist_d[n] = ref_data;
      hist_v[n] = ref_valid;
      wm = (n >= W + 1);
      if (n >= D) begin
         ra = hist_d[n-D]; rva = hist_v[n-D];
      end else begin
         ra = '0; rva = 1'b0;
      end
      v = '0; m = 1'b0;
      if (wm && (rva != uut_valid)) begin
         v = ~ch_mask; m = 1'b1;
      end else if (wm && rva && uut_valid) begin
         for (int k = 0; k < NCH; k++)
            v[k] = !ch_mask[k] && (chan(ra, k) != chan(uut_data, k));
         m = (v != '0);
      end
      lo = NCH - 1;
      for (int k = 0; k < NCH; k++)
         if (v[k] && lo == NCH - 1 && (k < lo || v[k])) begin
            lo = k;
            break;
         end
      if (clear) begin
         e_mis = 1'b0; e_vec = '0; e_fail = 1'b0; e_ch = 0; e_cyc = 0;
         e_ref = 0; e_uut = 0; e_cnt = 0;
      end else begin
         e_mis = m; e_vec = v;
         if (m) begin
            if (!e_fail) begin
               e_ch = lo; e_cyc = n; e_ref = chan(ra, lo); e_uut = chan(uut_data, lo);
            end
            e_fail = 1'b1;
            if (e_cnt < CMAX) e_cnt++;
         end
      end
      n++;
      e_warm = (n >= W + 1);
   endtask

   initial begin
      int pe;
      rst = 1'b1; ref_valid = 1'b0; ref_data = '0; uut_valid = 1'b0;
      uut_data = '0; ch_mask = '0; clear = 1'b0;
      @(posedge clk);
      @(posedge clk);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         chk("mismatch", mismatch, e_mis);
         chk("vec", mismatch_vec, e_vec);
         chk("fail", fail, e_fail);
         chk("first_ch", first_ch, 64'(e_ch));
         chk("first_cycle", first_cycle, 64'(e_cyc));
         chk("first_ref", first_ref, 64'(e_ref));
         chk("first_uut", first_uut, 64'(e_uut));
         chk("cnt", mismatch_cnt, 64'(e_cnt));
         chk("warm", warm, e_warm);
         pe = (c < 1000) ? 4 : (c < 2000) ? 25 : 8;
         rst = (c < 3) || (n >= 4000) || ($urandom_range(0, 299) == 0);
         clear = ($urandom_range(0, 99) < 2);
         ref_data = $urandom;
         ref_valid = ($urandom_range(0, 7) != 0);
         if (n >= D) begin
            uut_data = hist_d[n-D]; uut_valid = hist_v[n-D];
         end else begin
            uut_data = $urandom; uut_valid = 1'b0;
         end
         if ($urandom_range(0, 99) < pe)
            uut_data = uut_data ^ ((NCH*CW)'($urandom_range(1, 255)) << (CW * $urandom_range(0, NCH-1)));
         if ($urandom_range(0, 99) < pe / 4 + 1)
            uut_valid = ~uut_valid;
         case ($urandom_range(0, 7))
            0:       ch_mask = 4'hF;
            1, 2:    ch_mask = 4'($urandom);
            default: ch_mask = 4'h0;
         endcase
         step_model();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
